alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width taken from SrcB[SHAMT_W-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 SrcA  input  WIDTH  operand A.
REQ-008 SrcB  input  WIDTH  operand B.
REQ-009 ALUControl  input  4  operation select (REQ-013).
REQ-010 out_valid  output  1  ALUResult/ZeroE valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 ALUResult  output  WIDTH  registered result; ZeroE  output  1  registered, high iff ALUResult == 0.

Function
REQ-013 Encodings SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU; 1110/1111 SHALL yield result 0.
REQ-014 ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; no overflow/carry outputs.
REQ-015 SLT/SLTU SHALL yield WIDTH-bit 1 or 0, zero-extended.
REQ-016 Shifts SHALL use only SrcB[SHAMT_W-1:0]; SRA SHALL replicate SrcA[WIDTH-1].
REQ-017 DIVU with SrcB==0 SHALL yield all ones; REMU with SrcB==0 SHALL yield SrcA.
REQ-018 Request accepted in a cycle where in_valid && in_ready; SrcA, SrcB, ALUControl SHALL be captured at acceptance and SHALL NOT be sampled again.
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE + accept of single-cycle op (0000-1001, 1110, 1111) -> DONE; out_valid high the next cycle (latency 1).
REQ-021 IDLE + accept of MUL/MULHU/DIVU/REMU -> BUSY; iterative shift-add multiply / restoring divide, one bit per cycle, iteration counter WIDTH..1.
REQ-022 BUSY SHALL last exactly WIDTH cycles, then -> DONE; out_valid asserted WIDTH+1 cycles after acceptance, independent of operand values (including divide-by-zero).
REQ-023 in_ready SHALL be high in IDLE, high in DONE when out_ready is high, low in BUSY and low in DONE when out_ready is low.
REQ-024 DONE with out_ready low: ALUResult, ZeroE, out_valid SHALL hold stable.
REQ-025 DONE with out_ready high and no new accept -> IDLE, out_valid low next cycle.
REQ-026 DONE with out_ready high and simultaneous accept: handled as accept from IDLE (next state DONE or BUSY), giving back-to-back single-cycle throughput of one result per cycle.
REQ-027 in_valid while in_ready low SHALL be ignored; ALUControl changes during BUSY SHALL have no effect.
REQ-028 ALUResult and ZeroE SHALL change only on transition into DONE.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, out_valid=0, ALUResult=0, ZeroE=0, iteration counter=0, from any state including mid-BUSY; the in-flight operation SHALL be discarded without output.
REQ-030 in_ready SHALL be low in any cycle rst is high and high the first cycle after rst is released.

Verification
REQ-031 WIDTH=64, ADD SrcA=0xFFFF_FFFF_FFFF_FFFF, SrcB=1 -> next cycle out_valid=1, ALUResult=0, ZeroE=1.
REQ-032 WIDTH=64, SLT SrcA=-1, SrcB=1 -> ALUResult=1; SLTU same operands -> ALUResult=0; SRA SrcA=0x8000_0000_0000_0000, SrcB=0x43 -> 0xF000_0000_0000_0000.
REQ-033 WIDTH=64, MUL SrcA=0x1_0000_0003, SrcB=0x1_0000_0005 -> out_valid exactly 65 cycles after accept, ALUResult=0x8_0000_000F; MULHU same -> 0x1; in_ready low throughout BUSY.
REQ-034 WIDTH=32, DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU x/0 -> 0xFFFF_FFFF; REMU 0x1234/0 -> 0x1234; each after 33 cycles.
REQ-035 Backpressure: ADD result with out_ready low for 5 cycles -> outputs stable, in_ready low; then out_ready high with in_valid high, ops ADD,SUB,XOR streamed -> one result per cycle, in order.
REQ-036 Reset mid-operation: DIVU accepted, rst asserted 10 cycles later for 1 cycle -> next cycle IDLE, out_valid=0, ALUResult=0; no result ever delivered for the aborted DIVU.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_multicycle #(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             ZeroE
);

   localparam int CNT_W = SHAMT_W + 1;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0110;
   localparam logic [3:0] OP_SLL   = 4'b0111;
   localparam logic [3:0] OP_SRL   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

   stateType         state;
   logic [3:0]       opReg;
   logic [WIDTH-1:0] hiReg;    // product high half / partial remainder
   logic [WIDTH-1:0] loReg;    // multiplier being consumed / quotient
   logic [WIDTH-1:0] opndReg;  // multiplicand / divisor
   logic [CNT_W-1:0] iterCount;
   logic [WIDTH-1:0] resultReg;
   logic             zeroReg;

   logic             accept;
   logic             newIsMulti;
   logic             newIsMul;
   logic [WIDTH-1:0] singleResult;
   logic [SHAMT_W-1:0] shamt;

   logic             isMulOp;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift;
   logic             divGe;
   logic [WIDTH-1:0] nextHi;
   logic [WIDTH-1:0] nextLo;
   logic [WIDTH-1:0] iterResult;

   assign in_ready   = !rst && (state == IDLE || (state == DONE && out_ready));
   assign accept     = in_valid && in_ready;
   assign out_valid  = (state == DONE);
   assign ALUResult  = resultReg;
   assign ZeroE      = zeroReg;
   assign shamt      = SrcB[SHAMT_W-1:0];
   assign newIsMulti = (ALUControl >= OP_MUL) && (ALUControl <= OP_REMU);
   assign newIsMul   = (ALUControl == OP_MUL) || (ALUControl == OP_MULHU);
   assign isMulOp    = (opReg == OP_MUL) || (opReg == OP_MULHU);

   // NOTE: every signal assigned in always_comb gets a default first so that
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      singleResult = '0;
      case (ALUControl)
         OP_ADD:  singleResult = SrcA + SrcB;
         OP_SUB:  singleResult = SrcA - SrcB;
         OP_AND:  singleResult = SrcA & SrcB;
         OP_OR:   singleResult = SrcA | SrcB;
         OP_XOR:  singleResult = SrcA ^ SrcB;
         OP_SLT:  singleResult = WIDTH'($signed(SrcA) < $signed(SrcB));
         OP_SLTU: singleResult = WIDTH'(SrcA < SrcB);
         OP_SLL:  singleResult = SrcA << shamt;
         OP_SRL:  singleResult = SrcA >> shamt;
         OP_SRA:  singleResult = WIDTH'($signed(SrcA) >>> shamt);
         default: singleResult = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide.
   always_comb begin
      mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, opndReg} : '0);
      divShift = {hiReg, loReg[WIDTH-1]};
      divGe    = divShift >= {1'b0, opndReg};
      nextHi   = '0;
      nextLo   = '0;
      if (isMulOp) begin
         nextHi = mulSum[WIDTH:1];
         nextLo = {mulSum[0], loReg[WIDTH-1:1]};
      end else begin
         nextHi = divGe ? WIDTH'(divShift - {1'b0, opndReg}) : divShift[WIDTH-1:0];
         nextLo = {loReg[WIDTH-2:0], divGe};
      end
      // MULHU/REMU (odd encodings) take the high/remainder half.
      iterResult = opReg[0] ? nextHi : nextLo;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   // NOTE: the iteration datapath (opReg/hiReg/loReg/opndReg) is not reset;
   // it is always loaded at acceptance before being read.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         iterCount <= '0;
         resultReg <= '0;
         zeroReg   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  opReg <= ALUControl;
                  if (newIsMulti) begin
                     state     <= BUSY;
                     iterCount <= CNT_W'(WIDTH);
                     hiReg     <= '0;
                     loReg     <= newIsMul ? SrcB : SrcA;
                     opndReg   <= newIsMul ? SrcA : SrcB;
                  end else begin
                     state     <= DONE;
                     resultReg <= singleResult;
                     zeroReg   <= (singleResult == '0);
                  end
               end else if (state == DONE && out_ready) begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               hiReg     <= nextHi;
               loReg     <= nextLo;
               iterCount <= iterCount - CNT_W'(1);
               if (iterCount == CNT_W'(1)) begin
                  state     <= DONE;
                  resultReg <= iterResult;
                  zeroReg   <= (iterResult == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 64-bit instance for the general
// function and a 32-bit instance for the divider vectors.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        rst;

   logic        inValid64, inReady64, outValid64, outReady64, zero64;
   logic [63:0] srcA64, srcB64, result64;
   logic [3:0]  ctrl64;

   logic        inValid32, inReady32, outValid32, outReady32, zero32;
   logic [31:0] srcA32, srcB32, result32;
   logic [3:0]  ctrl32;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst),
      .in_valid(inValid64), .in_ready(inReady64),
      .SrcA(srcA64), .SrcB(srcB64), .ALUControl(ctrl64),
      .out_valid(outValid64), .out_ready(outReady64),
      .ALUResult(result64), .ZeroE(zero64)
   );

   alu_multicycle #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst),
      .in_valid(inValid32), .in_ready(inReady32),
      .SrcA(srcA32), .SrcB(srcB32), .ALUControl(ctrl32),
      .out_valid(outValid32), .out_ready(outReady32),
      .ALUResult(result32), .ZeroE(zero32)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op on the 64-bit instance and check result, zero flag, latency.
   // While BUSY, garbage requests are driven and must be ignored.
   task automatic runOp64(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] expRes, input int expLat);
      int lat;
      logic readyLeak;
      readyLeak  = 1'b0;
      outReady64 = 1'b1;
      inValid64  = 1'b1;
      ctrl64     = op;
      srcA64     = a;
      srcB64     = b;
      tick();
      lat = 1;
      while (!outValid64 && lat < 200) begin
         readyLeak = readyLeak | inReady64;
         inValid64 = 1'b1;
         ctrl64    = 4'($urandom_range(0, 15));
         srcA64    = {$urandom, $urandom};
         srcB64    = {$urandom, $urandom};
         tick();
         lat++;
      end
      inValid64 = 1'b0;
      check({tag, "_lat"}, 64'(lat), 64'(expLat));
      check({tag, "_res"}, result64, expRes);
      check({tag, "_zero"}, {63'd0, zero64}, {63'd0, expRes == 64'd0});
      if (expLat > 1) check({tag, "_busy_ready"}, {63'd0, readyLeak}, 64'd0);
      tick();
      check({tag, "_drain"}, {63'd0, outValid64}, 64'd0);
   endtask

   task automatic runOp32(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expRes);
      int lat;
      outReady32 = 1'b1;
      inValid32  = 1'b1;
      ctrl32     = op;
      srcA32     = a;
      srcB32     = b;
      tick();
      inValid32 = 1'b0;
      ctrl32    = 4'b0000;
      srcA32    = 32'hDEAD_BEEF;
      lat = 1;
      while (!outValid32 && lat < 200) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd33);
      check({tag, "_res"}, {32'd0, result32}, {32'd0, expRes});
      tick();
   endtask

   initial begin
      logic sawValid;
      inValid64 = 1'b0; outReady64 = 1'b1; srcA64 = '0; srcB64 = '0; ctrl64 = '0;
      inValid32 = 1'b0; outReady32 = 1'b1; srcA32 = '0; srcB32 = '0; ctrl32 = '0;
      rst = 1'b1;
      tick();
      check("rst_in_ready_low", {63'd0, inReady64}, 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", {63'd0, outValid64}, 64'd0);
      check("rst_result", result64, 64'd0);
      check("rst_zero", {63'd0, zero64}, 64'd0);
      check("rst_in_ready_high", {63'd0, inReady64}, 64'd1);

      // Single-cycle ops, latency 1.
      runOp64("add_wrap", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
      runOp64("sub",      4'b0001, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
      runOp64("and",      4'b0010, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_FF00, 64'h00F0_0000_00FF_1200, 1);
      runOp64("or",       4'b0011, 64'h0000_0000_0000_00F0, 64'h1000_0000_0000_000F, 64'h1000_0000_0000_00FF, 1);
      runOp64("xor",      4'b0100, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_0000_0000, 64'h5555_5555_AAAA_AAAA, 1);
      runOp64("slt",      4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
      runOp64("sltu",     4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
      runOp64("sll",      4'b0111, 64'd1, 64'h41, 64'd2, 1);
      runOp64("srl",      4'b1000, 64'h8000_0000_0000_0000, 64'h104, 64'h0800_0000_0000_0000, 1);
      runOp64("sra",      4'b1001, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1);
      runOp64("op1110",   4'b1110, 64'd123, 64'd456, 64'd0, 1);
      runOp64("op1111",   4'b1111, 64'd123, 64'd456, 64'd0, 1);

      // Iterative ops, latency WIDTH+1.
      runOp64("mul",   4'b1010, 64'h1_0000_0003, 64'h1_0000_0005, 64'h8_0000_000F, 65);
      runOp64("mulhu", 4'b1011, 64'h1_0000_0003, 64'h1_0000_0005, 64'h1, 65);
      runOp64("mulhu_max", 4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      runOp64("divu64", 4'b1100, 64'd1000, 64'd3, 64'd333, 65);
      runOp64("divu64_by0", 4'b1100, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65);

      runOp32("divu32", 4'b1100, 32'd100, 32'd7, 32'd14);
      runOp32("remu32", 4'b1101, 32'd100, 32'd7, 32'd2);
      runOp32("divu32_by0", 4'b1100, 32'd5, 32'd0, 32'hFFFF_FFFF);
      runOp32("remu32_by0", 4'b1101, 32'h1234, 32'd0, 32'h1234);

      // Backpressure: hold an ADD result for 5 cycles, then stream three ops.
      outReady64 = 1'b0;
      inValid64  = 1'b1; ctrl64 = 4'b0000; srcA64 = 64'd3; srcB64 = 64'd4;
      tick();
      ctrl64 = 4'b0001; srcA64 = 64'd99; srcB64 = 64'd1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {63'd0, outValid64}, 64'd1);
         check("bp_result", result64, 64'd7);
         check("bp_in_ready", {63'd0, inReady64}, 64'd0);
         tick();
      end
      outReady64 = 1'b1;
      ctrl64 = 4'b0000; srcA64 = 64'd10; srcB64 = 64'd20;
      #1;
      check("bp_release_ready", {63'd0, inReady64}, 64'd1);
      tick();
      check("stream_add", result64, 64'd30);
      check("stream_add_valid", {63'd0, outValid64}, 64'd1);
      ctrl64 = 4'b0001; srcA64 = 64'd50; srcB64 = 64'd8;
      tick();
      check("stream_sub", result64, 64'd42);
      check("stream_sub_valid", {63'd0, outValid64}, 64'd1);
      ctrl64 = 4'b0100; srcA64 = 64'hF0; srcB64 = 64'hFF;
      tick();
      check("stream_xor", result64, 64'h0F);
      check("stream_xor_valid", {63'd0, outValid64}, 64'd1);
      inValid64 = 1'b0;
      tick();
      check("stream_end", {63'd0, outValid64}, 64'd0);

      // Reset in the middle of a DIVU: the result must never appear.
      inValid64 = 1'b1; ctrl64 = 4'b1100; srcA64 = 64'd1000; srcB64 = 64'd3;
      tick();
      inValid64 = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      #1;
      check("midrst_in_ready", {63'd0, inReady64}, 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_valid", {63'd0, outValid64}, 64'd0);
      check("midrst_result", result64, 64'd0);
      check("midrst_zero", {63'd0, zero64}, 64'd0);
      check("midrst_ready", {63'd0, inReady64}, 64'd1);
      sawValid = 1'b0;
      for (int i = 0; i < 80; i++) begin
         sawValid = sawValid | outValid64;
         tick();
      end
      check("midrst_no_result", {63'd0, sawValid}, 64'd0);

      // Still functional after the abort.
      runOp64("post_rst_remu", 4'b1101, 64'd1000, 64'd3, 64'd1, 65);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
